// File: rtl/shift_sequencer_if.sv
// Request/result handshake plus the barrel-shifter drive/return lines for shift_sequencer.
// Vectors use index 0 as MSB to match the shifter's port ordering.
interface shift_sequencer_if #(
    parameter int DW    = 8,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [0:DW-1]    in_data;
    logic             in_dir;
    logic [0:AMT_W-1] in_amt;
    logic [0:DW-1]    sh_Ip;
    logic [0:4]       sh_mag;
    logic [0:DW-1]    sh_Op;
    logic             out_valid;
    logic             out_ready;
    logic [0:DW-1]    out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_dir, in_amt, sh_Op, out_ready,
        output in_ready, sh_Ip, sh_mag, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_dir, in_amt, sh_Op, out_ready,
        input  in_ready, sh_Ip, sh_mag, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Splits a 0..2^AMT_W-1 position shift into passes of at most MAX_STEP through an
// external 8-bit barrel shifter, feeding its output back until the request is done.
module shift_sequencer #(
    parameter int DW       = 8,
    parameter int AMT_W    = 3,
    parameter int MAX_STEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    localparam logic [0:4] MAG_NONE = 5'b00100;

    state_t           state;
    logic [0:DW-1]    acc;
    logic [AMT_W-1:0] rem;
    logic             dir;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [1:0]       step;
    logic [AMT_W-1:0] rem_next;

    function automatic logic [0:4] mag_code(input logic d, input logic [1:0] s);
        logic [0:4] m;
        case ({d, s})
            3'b1_10: m = 5'b10000;
            3'b1_01: m = 5'b01000;
            3'b0_01: m = 5'b00010;
            3'b0_10: m = 5'b00001;
            default: m = MAG_NONE;
        endcase
        return m;
    endfunction

    assign step     = (rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
    assign rem_next = rem - AMT_W'(step);

    // The shifter only ever sees a legal one-hot code; outside STEP it is told to pass through.
    assign bus.sh_Ip     = reset ? '0 : acc;
    assign bus.sh_mag    = (reset || state != STEP) ? MAG_NONE : mag_code(dir, step);
    assign bus.out_data  = acc;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            rem         <= '0;
            dir         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        acc        <= bus.in_data;
                        rem        <= bus.in_amt;
                        dir        <= bus.in_dir;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.in_amt != '0) begin
                            state <= STEP;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    acc <= bus.sh_Op;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; no re-accept in the same cycle.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: two builds (MAX_STEP=2 and MAX_STEP=1) each
// driving a behavioural barrel shifter; expected results and shifter codes are queued.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    logic pva = 1'b0;
    logic pvb = 1'b0;

    typedef struct {
        logic [0:7] data;
        int         lat;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [0:4] mq[$];

    shift_sequencer_if #(.DW(8), .AMT_W(3)) ifa ();
    shift_sequencer_if #(.DW(8), .AMT_W(3)) ifb ();

    shift_sequencer #(.DW(8), .AMT_W(3), .MAX_STEP(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    shift_sequencer #(.DW(8), .AMT_W(3), .MAX_STEP(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural barrel shifter: zero fill, illegal codes give 0.
    function automatic logic [0:7] shifter(input logic [0:7] ip, input logic [0:4] mag);
        case (mag)
            5'b10000: return ip >> 2;
            5'b01000: return ip >> 1;
            5'b00100: return ip;
            5'b00010: return ip << 1;
            5'b00001: return ip << 2;
            default:  return 8'h00;
        endcase
    endfunction

    assign ifa.sh_Op = shifter(ifa.sh_Ip, ifa.sh_mag);
    assign ifb.sh_Op = shifter(ifb.sh_Ip, ifb.sh_mag);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic mon(input string tag, input logic ov, input logic [0:7] od, input logic orr,
                       input logic [0:4] mg, inout logic pv);
        if (mg !== 5'b00100) begin
            if (mq.size() == 0) fail({tag, "_mag_unexpected"}, mg);
            else chk({tag, "_mag"}, mg, mq.pop_front());
        end
        if (ov === 1'b1) begin
            if (q.size() == 0) begin
                fail({tag, "_result_unexpected"}, od);
            end else begin
                if (pv !== 1'b1) begin
                    chk({tag, "_data"}, od, q[0].data);
                    chk({tag, "_latency"}, cyc - q[0].cyc, q[0].lat);
                end else begin
                    chk({tag, "_data_stable"}, od, q[0].data);
                end
                if (orr === 1'b1) void'(q.pop_front());
            end
        end
        pv = ov;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                mon("a", ifa.out_valid, ifa.out_data, ifa.out_ready, ifa.sh_mag, pva);
                mon("b", ifb.out_valid, ifb.out_data, ifb.out_ready, ifb.sh_mag, pvb);
            end
        end
    end

    task automatic drive(input bit b, input logic v, input logic [0:7] d, input logic dr, input logic [0:2] amt);
        if (b) begin
            ifb.in_valid = v; ifb.in_data = d; ifb.in_dir = dr; ifb.in_amt = amt;
        end else begin
            ifa.in_valid = v; ifa.in_data = d; ifa.in_dir = dr; ifa.in_amt = amt;
        end
    endtask

    task automatic issue(input bit b, input logic [0:7] d, input logic dr, input logic [0:2] amt,
                         input logic [0:7] ed, input int lat, input bit expect_out);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk); #1;
        drive(b, 1'b1, d, dr, amt);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((b ? ifb.in_ready : ifa.in_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(b ? "b_accept" : "a_accept", ok, 1);
        if (ok && expect_out) begin
            e.data = ed; e.lat = lat; e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        // Garbage on the request bus while busy must be ignored.
        drive(b, 1'b0, 8'h5A, ~dr, 3'd7);
    endtask

    task automatic wait_done(input bit b);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && (b ? ifb.in_ready : ifa.in_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(b ? "b_done" : "a_done", ok, 1);
        chk("mag_queue_drained", mq.size(), 0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sh_Ip", ifa.sh_Ip, 8'h00);
        chk("rst_sh_mag", ifa.sh_mag, 5'b00100);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_idle_mag", ifa.sh_mag, 5'b00100);
        mon_en = 1'b1;

        // left 3
        mq.push_back(5'b00001); mq.push_back(5'b00010);
        issue(1'b0, 8'b1010_1101, 1'b0, 3'd3, 8'b0110_1000, 3, 1'b1);
        wait_done(1'b0);

        // right 5
        mq.push_back(5'b10000); mq.push_back(5'b10000); mq.push_back(5'b01000);
        issue(1'b0, 8'b1010_1101, 1'b1, 3'd5, 8'b0000_0101, 4, 1'b1);
        wait_done(1'b0);

        // zero shift: no STEP pass
        issue(1'b0, 8'b0000_0001, 1'b0, 3'd0, 8'b0000_0001, 1, 1'b1);
        wait_done(1'b0);

        // single passes
        mq.push_back(5'b00010);
        issue(1'b0, 8'b1100_0011, 1'b0, 3'd1, 8'b1000_0110, 2, 1'b1);
        wait_done(1'b0);
        mq.push_back(5'b10000);
        issue(1'b0, 8'b1100_0011, 1'b1, 3'd2, 8'b0011_0000, 2, 1'b1);
        wait_done(1'b0);

        // backpressure on a full-length left 7
        ifa.out_ready = 1'b0;
        mq.push_back(5'b00001); mq.push_back(5'b00001); mq.push_back(5'b00001); mq.push_back(5'b00010);
        issue(1'b0, 8'b1111_1111, 1'b0, 3'd7, 8'b1000_0000, 5, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ifa.out_valid === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("bp_out_valid_seen", seen, 1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", ifa.in_ready, 0);
            chk("bp_out_valid", ifa.out_valid, 1);
            chk("bp_busy", ifa.busy, 1);
        end
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_after_in_ready", ifa.in_ready, 1);
        chk("bp_after_out_valid", ifa.out_valid, 0);
        chk("bp_after_busy", ifa.busy, 0);
        chk("bp_queue", q.size(), 0);

        // reset in the second STEP cycle of a left 6
        mq.push_back(5'b00001);
        issue(1'b0, 8'b1111_1111, 1'b0, 3'd6, 8'h00, 0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sh_mag", ifa.sh_mag, 5'b00100);
        chk("midrst_sh_Ip", ifa.sh_Ip, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", ifa.in_ready, 1);
        chk("postrst_out_valid", ifa.out_valid, 0);
        chk("postrst_busy", ifa.busy, 0);
        chk("postrst_sh_mag", ifa.sh_mag, 5'b00100);
        chk("postrst_acc", ifa.out_data, 8'h00);
        repeat (8) @(negedge clk);
        chk("postrst_mag_queue", mq.size(), 0);

        // MAX_STEP=1 build, right 3
        mq.push_back(5'b01000); mq.push_back(5'b01000); mq.push_back(5'b01000);
        issue(1'b1, 8'b1000_0000, 1'b1, 3'd3, 8'b0001_0000, 4, 1'b1);
        wait_done(1'b1);

        repeat (3) @(negedge clk);
        chk("final_result_queue", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
